pkt_rx_ctrl: RTL and testbench

Serial packet receive controller: assembles bits into bytes, hunts for a header byte (0xA5 or 0xC3) on a sliding bit window, then sequences a fixed-length payload and optional checksum byte. It replaces ad-hoc use of the combinational header detector with a single clocked sequencer. It sits between the serial line sampler and the downstream byte consumer.

---
 rtl/pkt_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pkt_rx_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pkt_rx_ctrl
//  Purpose  : Serial packet receive controller. Shifts serial bits (MSB
//             first) into a byte window, hunts for a header byte (0xA5 or
//             0xC3) on a sliding bit window, then delivers PAYLOAD_BYTES
//             byte-aligned payload bytes. An optional trailing XOR checksum
//             byte is verified when PKT_RX_CHECKSUM_EN is defined.
//  Ports    : clk        - rising-edge clock
//             reset      - synchronous, active-high reset
//             serial_in  - data bit, sampled when bit_valid = 1
//             bit_valid  - qualifies serial_in; no state change when low
//             hdr_found  - 1-cycle pulse when a header is accepted
//             hdr_type   - 0 = 0xA5, 1 = 0xC3; held until next hdr_found
//             byte_out   - payload byte; holds until next byte_valid
//             byte_valid - 1-cycle pulse per payload byte
//             pkt_done   - 1-cycle pulse: packet complete (and good)
//             pkt_err    - 1-cycle pulse: checksum mismatch
//  Config   : PKT_RX_CHECKSUM_EN - enables trailing checksum byte, the CHECK
//             state, the csum register and pkt_err (tied to 0 otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_rx_ctrl #(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       bit_valid,
  output logic       hdr_found,
  output logic       hdr_type,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_done,
  output logic       pkt_err
);

  localparam logic [7:0] HDR_A5    = 8'hA5;
  localparam logic [7:0] HDR_C3    = 8'hC3;
  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);
  localparam logic [3:0] FILL_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1
`ifdef PKT_RX_CHECKSUM_EN
    ,
    ST_CHECK   = 2'd2
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] fill_q, fill_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       hdr_found_q, hdr_found_d;
  logic       hdr_type_q, hdr_type_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_valid_q, byte_valid_d;
  logic       pkt_done_q, pkt_done_d;
`ifdef PKT_RX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       pkt_err_q, pkt_err_d;
`endif

  // Window and fill count as they will be after the bit currently offered.
  logic [7:0] sr_next;
  logic [3:0] fill_next;

  always_comb begin
    sr_next      = {sr_q[6:0], serial_in};
    fill_next    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;

    state_d      = state_q;
    sr_d         = sr_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    hdr_found_d  = 1'b0;
    hdr_type_d   = hdr_type_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    pkt_done_d   = 1'b0;
`ifdef PKT_RX_CHECKSUM_EN
    csum_d       = csum_q;
    pkt_err_d    = 1'b0;
`endif

    if (bit_valid) begin
      sr_d = sr_next;
      case (state_q)
        ST_HUNT: begin
          fill_d = fill_next;
          // Only a window made entirely of bits received since entering
          // HUNT may be taken as a header.
          if ((fill_next == FILL_FULL) && ((sr_next == HDR_A5) || (sr_next == HDR_C3))) begin
            hdr_found_d = 1'b1;
            hdr_type_d  = (sr_next == HDR_C3);
`ifdef PKT_RX_CHECKSUM_EN
            csum_d      = sr_next;
`endif
            bit_cnt_d   = 3'd0;
            byte_cnt_d  = 8'd0;
            state_d     = ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d   = sr_next;
            byte_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
`ifdef PKT_RX_CHECKSUM_EN
            csum_d       = csum_q ^ sr_next;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
`ifdef PKT_RX_CHECKSUM_EN
              // bit_cnt wraps to 0, so the checksum byte is aligned too.
              state_d    = ST_CHECK;
`else
              pkt_done_d = 1'b1;
              state_d    = ST_HUNT;
              fill_d     = 4'd0;
`endif
            end
          end
        end

`ifdef PKT_RX_CHECKSUM_EN
        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (sr_next == csum_q) begin
              pkt_done_d = 1'b1;
            end else begin
              pkt_err_d  = 1'b1;
            end
            state_d = ST_HUNT;
            fill_d  = 4'd0;
          end
        end
`endif

        default: begin
          state_d = ST_HUNT;
          fill_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      sr_q         <= 8'd0;
      fill_q       <= 4'd0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 8'd0;
      hdr_found_q  <= 1'b0;
      hdr_type_q   <= 1'b0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
`ifdef PKT_RX_CHECKSUM_EN
      csum_q       <= 8'd0;
      pkt_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      hdr_found_q  <= hdr_found_d;
      hdr_type_q   <= hdr_type_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_done_q   <= pkt_done_d;
`ifdef PKT_RX_CHECKSUM_EN
      csum_q       <= csum_d;
      pkt_err_q    <= pkt_err_d;
`endif
    end
  end

  assign hdr_found  = hdr_found_q;
  assign hdr_type   = hdr_type_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign pkt_done   = pkt_done_q;
`ifdef PKT_RX_CHECKSUM_EN
  assign pkt_err    = pkt_err_q;
`else
  assign pkt_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pkt_rx_ctrl
//  Purpose  : Self-checking bench for pkt_rx_ctrl. Observed output pulses are
//             logged as events tagged with the number of accepted bits; a
//             stream-parsing reference model produces the expected events.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_rx_ctrl;

  localparam int PB = 4;
`ifdef PKT_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam logic [7:0] K_HDR  = 8'd1;
  localparam logic [7:0] K_BYTE = 8'd2;
  localparam logic [7:0] K_DONE = 8'd3;
  localparam logic [7:0] K_ERR  = 8'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       hdr_found, hdr_type, byte_valid, pkt_done, pkt_err;
  logic [7:0] byte_out;

  pkt_rx_ctrl #(.PAYLOAD_BYTES(PB)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .hdr_found  (hdr_found),
    .hdr_type   (hdr_type),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit          tx_bits[$];
  logic [31:0] obs_ev[$];
  logic [31:0] exp_ev[$];
  bit          mon_en = 1'b0;
  int          nbits = 0;
  logic        cur_type = 1'b0;
  logic [7:0]  cur_byte = 8'd0;
  bit          m_acc, m_rs;

  function automatic logic [31:0] mk_ev(logic [7:0] k, int cnt, logic [7:0] d);
    logic [15:0] c;
    c = cnt[15:0];
    return {k, c, d};
  endfunction

  // Monitor: log output pulses with the accepted-bit count, check holds.
  always begin
    @(posedge clk);
    m_acc = bit_valid;
    m_rs  = reset;
    #1;
    if (m_rs) begin
      nbits    = 0;
      cur_type = 1'b0;
      cur_byte = 8'd0;
    end else if (m_acc) begin
      nbits++;
    end
    if (mon_en) begin
      if (hdr_found)  obs_ev.push_back(mk_ev(K_HDR, nbits, {7'd0, hdr_type}));
      if (byte_valid) obs_ev.push_back(mk_ev(K_BYTE, nbits, byte_out));
      if (pkt_done)   obs_ev.push_back(mk_ev(K_DONE, nbits, 8'd0));
      if (pkt_err)    obs_ev.push_back(mk_ev(K_ERR, nbits, 8'd0));
      if (hdr_found) begin
        cur_type = hdr_type;
      end else begin
        checks++;
        if (hdr_type !== cur_type) begin
          errors++;
          $display("FAIL hdr_type_hold: got %b expected %b at %0t", hdr_type, cur_type, $time);
        end
      end
      if (byte_valid) begin
        cur_byte = byte_out;
      end else begin
        checks++;
        if (byte_out !== cur_byte) begin
          errors++;
          $display("FAIL byte_out_hold: got %h expected %h at %0t", byte_out, cur_byte, $time);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] get_byte(int s);
    logic [7:0] v;
    v = 8'd0;
    for (int i = 0; i < 8; i++) v = {v[6:0], logic'(tx_bits[s+i])};
    return v;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  // Reference model: parse tx_bits as a stream of packets.
  task automatic run_model();
    int n, hs, hq, pos;
    bit ok;
    logic [7:0] w, b, cs;
    exp_ev.delete();
    n  = tx_bits.size();
    hs = 0;
    while (1) begin
      hq = -1;
      w  = 8'd0;
      for (int q = hs + 7; q < n && hq < 0; q++) begin
        w = get_byte(q - 7);
        if (w == 8'hA5 || w == 8'hC3) hq = q;
      end
      if (hq < 0) break;
      exp_ev.push_back(mk_ev(K_HDR, hq + 1, {7'd0, (w == 8'hC3)}));
      cs  = w;
      pos = hq + 1;
      ok  = 1'b1;
      for (int k = 0; k < PB && ok; k++) begin
        if (pos + 8 > n) begin
          ok = 1'b0;
        end else begin
          b = get_byte(pos);
          pos += 8;
          exp_ev.push_back(mk_ev(K_BYTE, pos, b));
          cs ^= b;
        end
      end
      if (!ok) break;
      if (CK) begin
        if (pos + 8 > n) break;
        b = get_byte(pos);
        pos += 8;
        exp_ev.push_back(mk_ev((b == cs) ? K_DONE : K_ERR, pos, 8'd0));
      end else begin
        exp_ev.push_back(mk_ev(K_DONE, pos, 8'd0));
      end
      hs = pos;
    end
  endtask

  task automatic send_bits(input int gap_min, input int gap_max);
    int g;
    for (int i = 0; i < tx_bits.size(); i++) begin
      g = $urandom_range(gap_max, gap_min);
      repeat (g) begin
        @(negedge clk);
        bit_valid = 1'b0;
        serial_in = 1'($urandom);
      end
      @(negedge clk);
      bit_valid = 1'b1;
      serial_in = tx_bits[i];
    end
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bit_valid = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    mon_en    = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    obs_ev.delete();
    tx_bits.delete();
  endtask

  task automatic test_reset();
    logic [7:0] pat;
    do_reset();
    checks++;
    if ({hdr_found, hdr_type, byte_out, byte_valid, pkt_done, pkt_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {hdr_found, hdr_type, byte_out, byte_valid, pkt_done, pkt_err});
    end
    // Header bits offered while reset is held must be ignored.
    pat = 8'hA5;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      serial_in = pat[i];
      @(negedge clk);
    end
    reset     = 1'b0;
    bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_ev.size() !== 0) begin
      errors++;
      $display("FAIL reset_priority: got %0d events expected 0", obs_ev.size());
    end
  endtask

  task automatic test_basic();
    do_reset();
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02);
    add_byte(8'h03); add_byte(8'h04); add_byte(8'hA1);
    send_bits(0, 0);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL basic_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
    if (obs_ev.size() == 6) begin
      checks++;
      if (obs_ev[0] !== mk_ev(K_HDR, 8, 8'd0)) begin
        errors++;
        $display("FAIL basic_hdr: got %h expected %h", obs_ev[0], mk_ev(K_HDR, 8, 8'd0));
      end
      checks++;
      if (obs_ev[5] !== mk_ev(K_DONE, CK ? 48 : 40, 8'd0)) begin
        errors++;
        $display("FAIL basic_done: got %h expected %h", obs_ev[5], mk_ev(K_DONE, CK ? 48 : 40, 8'd0));
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    add_byte(8'hC3); add_byte(8'h10); add_byte(8'h20);
    add_byte(8'h30); add_byte(8'h40); add_byte(8'h83);
    send_bits(0, 1);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL misaligned_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL misaligned_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
    if (obs_ev.size() > 0) begin
      checks++;
      if (obs_ev[0] !== mk_ev(K_HDR, 11, 8'd1)) begin
        errors++;
        $display("FAIL misaligned_hdr: got %h expected %h", obs_ev[0], mk_ev(K_HDR, 11, 8'd1));
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02);
    add_byte(8'h03); add_byte(8'h04); add_byte(8'h00);
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02);
    add_byte(8'h03); add_byte(8'h04); add_byte(8'hA1);
    send_bits(0, 0);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL bad_csum_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL bad_csum_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02);
    send_bits(0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({hdr_found, hdr_type, byte_out, byte_valid, pkt_done, pkt_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 0",
               {hdr_found, hdr_type, byte_out, byte_valid, pkt_done, pkt_err});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL reset_mid_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
    obs_ev.delete();
    tx_bits.delete();
    add_byte(8'hC3); add_byte(8'h11); add_byte(8'h22);
    add_byte(8'h33); add_byte(8'h44); add_byte(8'hC3 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    send_bits(0, 0);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL reset_after_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL reset_after_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_gapped();
    do_reset();
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02);
    add_byte(8'h03); add_byte(8'h04); add_byte(8'hA1);
    send_bits(2, 2);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL gapped_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL gapped_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_byte(8'hA5); add_byte(8'hA5); add_byte(8'hC3);
    add_byte(8'hA5); add_byte(8'hC3); add_byte(8'h00);
    send_bits(0, 0);
    run_model();
    checks++;
    if (obs_ev.size() !== exp_ev.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      checks++;
      if (obs_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL b2b_ev%0d: got %h expected %h", i, obs_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] cs, b;
    int nnoise;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int p = 0; p < 2; p++) begin
        nnoise = $urandom_range(20, 0);
        for (int i = 0; i < nnoise; i++) tx_bits.push_back(1'($urandom));
        cs = ($urandom_range(1, 0) == 1) ? 8'hC3 : 8'hA5;
        add_byte(cs);
        for (int k = 0; k < PB; k++) begin
          b = 8'($urandom);
          add_byte(b);
          cs ^= b;
        end
        add_byte(($urandom_range(3, 0) == 0) ? 8'($urandom) : cs);
      end
      send_bits(0, 3);
      run_model();
      checks++;
      if (obs_ev.size() !== exp_ev.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d expected %0d", it, obs_ev.size(), exp_ev.size());
      end
      for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
        checks++;
        if (obs_ev[i] !== exp_ev[i]) begin
          errors++;
          $display("FAIL random%0d_ev%0d: got %h expected %h", it, i, obs_ev[i], exp_ev[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_bad_csum();
    test_reset_mid();
    test_gapped();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
